// File: rtl/switch_debounce_sync.sv
// Per-channel switch conditioner: 2-flop sync, consecutive-cycle debounce, registered level and rise/fall pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from s1 capture to sw_db/pulse update; SWITCH_DEBOUNCE_INIT_SAMPLE_EN loads sw_db from s2 on the 3rd post-reset edge.
// Backpressure: none; free-running, every channel evaluated every cycle.
module switch_debounce_sync #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_async,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] sw_db_d;
    logic [WIDTH-1:0] sw_rise_d;
    logic [WIDTH-1:0] sw_fall_d;
    logic             run;
    logic             init_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_async;
            s2 <= s1;
        end
    end

`ifdef SWITCH_DEBOUNCE_INIT_SAMPLE_EN
    // Hold off debouncing until the synchronizer carries real pin levels, then adopt them silently.
    logic       init_q;
    logic [1:0] init_cnt_q;

    assign init_load = init_q && (init_cnt_q == 2'd2);
    assign run       = ~init_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q     <= 1'b1;
            init_cnt_q <= 2'd0;
        end else if (init_load) begin
            init_q     <= 1'b0;
        end else if (init_q) begin
            init_cnt_q <= init_cnt_q + 2'd1;
        end
    end
`else
    assign init_load = 1'b0;
    assign run       = 1'b1;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic             mismatch;

        assign mismatch  = run && (s2[i] != sw_db[i]);
        // The compare at CNT_MAX bounds the counter, so it never wraps.
        assign accept[i] = mismatch && (cnt_q == CNT_MAX);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (mismatch && !accept[i]) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    always_comb begin
        sw_db_d   = (sw_db & ~accept) | (s2 & accept);
        sw_rise_d = accept & s2;
        sw_fall_d = accept & ~s2;
        if (init_load) begin
            sw_db_d   = s2;
            sw_rise_d = '0;
            sw_fall_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_db   <= '0;
            sw_rise <= '0;
            sw_fall <= '0;
        end else begin
            sw_db   <= sw_db_d;
            sw_rise <= sw_rise_d;
            sw_fall <= sw_fall_d;
        end
    end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Bench for switch_debounce_sync: directed scenarios plus random switch activity against a window-based reference.
// The reference accepts a new level when the last DEBOUNCE_CYCLES synchronized samples all disagree with it.
module tb_switch_debounce_sync;

    localparam int W = 3;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_async;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;

    int checks = 0;
    int errors = 0;

    switch_debounce_sync #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_async (sw_async),
        .sw_db    (sw_db),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall)
    );

    always #5 clk = ~clk;

    // Reference: m_pipe is the two-sample sync delay, m_hist the synchronized samples seen since reset.
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_db;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    int           m_edges;

    task automatic model_clear();
        m_pipe.delete();
        m_pipe.push_back('0);
        m_pipe.push_back('0);
        m_hist.delete();
        m_db    = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_edges = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] x, input logic r);
        logic [W-1:0] s2v;
        logic         all_differ;
        if (r) begin
            model_clear();
            return;
        end
        s2v = m_pipe.pop_front();
        m_pipe.push_back(x);
        m_edges++;
        m_rise = '0;
        m_fall = '0;
`ifdef SWITCH_DEBOUNCE_INIT_SAMPLE_EN
        if (m_edges < 3) return;
        if (m_edges == 3) begin
            m_db = s2v;
            return;
        end
`endif
        m_hist.push_back(s2v);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        if (m_hist.size() == D) begin
            for (int ch = 0; ch < W; ch++) begin
                all_differ = 1'b1;
                for (int k = 0; k < D; k++)
                    if (m_hist[k][ch] == m_db[ch]) all_differ = 1'b0;
                if (all_differ) begin
                    m_db[ch]   = ~m_db[ch];
                    m_rise[ch] = m_db[ch];
                    m_fall[ch] = ~m_db[ch];
                end
            end
        end
    endtask

    // One clock: inputs change on the falling edge, outputs are observed 1 ns after the rising edge.
    task automatic cyc(input logic [W-1:0] x, input logic r);
        @(negedge clk);
        rst      = r;
        sw_async = x;
        if (r) model_clear();
        @(posedge clk);
        model_edge(x, r);
        #1;
    endtask

    task automatic do_reset(input logic [W-1:0] x, input int n);
        for (int k = 0; k < n; k++) cyc(x, 1'b1);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            cyc('1, 1'b1);
            checks++;
            if ({sw_db, sw_rise, sw_fall} !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got db=%b rise=%b fall=%b want all 0", k, sw_db, sw_rise, sw_fall);
            end
        end
        cyc('1, 1'b0);
        checks++;
        if ({sw_db, sw_rise, sw_fall} !== '0) begin
            errors++;
            $display("FAIL reset_release got db=%b rise=%b fall=%b want all 0", sw_db, sw_rise, sw_fall);
        end
    endtask

    task automatic test_clean_step();
        do_reset('0, 2);
        cyc('0, 1'b0);
        cyc('0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cyc(3'b001, 1'b0);
            checks++;
            if ({sw_db, sw_rise, sw_fall} !== {m_db, m_rise, m_fall}) begin
                errors++;
                $display("FAIL clean_model k=%0d got db=%b rise=%b fall=%b want db=%b rise=%b fall=%b",
                         k, sw_db, sw_rise, sw_fall, m_db, m_rise, m_fall);
            end
            if (k == 4) begin
                checks++;
                if (sw_db !== 3'b000) begin
                    errors++;
                    $display("FAIL clean_early got db=%b want 000", sw_db);
                end
            end
            if (k == 5) begin
                checks++;
                if ({sw_db, sw_rise, sw_fall} !== {3'b001, 3'b001, 3'b000}) begin
                    errors++;
                    $display("FAIL clean_edge got db=%b rise=%b fall=%b want db=001 rise=001 fall=000", sw_db, sw_rise, sw_fall);
                end
            end
            if (k == 6) begin
                checks++;
                if (sw_rise !== 3'b000) begin
                    errors++;
                    $display("FAIL clean_pulse_width got rise=%b want 000", sw_rise);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int   lv[7] = '{1, 1, 1, 0, 1, 1, 0};
        int   rises = 0;
        logic b;
        do_reset('0, 2);
        for (int k = 0; k < 17; k++) begin
            b = (k < 7) ? lv[k][0] : 1'b1;
            cyc({1'b0, b, 1'b0}, 1'b0);
            if (sw_rise[1]) rises++;
            checks++;
            if ({sw_db, sw_rise, sw_fall} !== {m_db, m_rise, m_fall}) begin
                errors++;
                $display("FAIL bounce_model k=%0d got db=%b rise=%b fall=%b want db=%b rise=%b fall=%b",
                         k, sw_db, sw_rise, sw_fall, m_db, m_rise, m_fall);
            end
            if (k == 11 || k == 12) begin
                checks++;
                if ({sw_db[1], sw_rise[1]} !== ((k == 12) ? 2'b11 : 2'b00)) begin
                    errors++;
                    $display("FAIL bounce_accept k=%0d got db1=%b rise1=%b want %0d", k, sw_db[1], sw_rise[1], (k == 12));
                end
            end
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL bounce_rise_count got %0d want 1", rises);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        int rise_at = -1;
        int fall_at = -1;
        do_reset('0, 2);
        for (int k = 0; k < 11; k++) begin
            cyc((k < 3) ? 3'b100 : 3'b000, 1'b0);
            if (sw_rise[2] || sw_fall[2] || sw_db[2]) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL glitch_3 got %0d active cycles want 0", pulses);
        end
        for (int k = 0; k < 14; k++) begin
            cyc((k < 4) ? 3'b100 : 3'b000, 1'b0);
            if (sw_rise[2]) rise_at = k;
            if (sw_fall[2]) fall_at = k;
            checks++;
            if ({sw_db, sw_rise, sw_fall} !== {m_db, m_rise, m_fall}) begin
                errors++;
                $display("FAIL glitch_model k=%0d got db=%b rise=%b fall=%b want db=%b rise=%b fall=%b",
                         k, sw_db, sw_rise, sw_fall, m_db, m_rise, m_fall);
            end
        end
        checks++;
        if (rise_at != 5 || fall_at != 9) begin
            errors++;
            $display("FAIL glitch_4 got rise_at=%0d fall_at=%0d want 5 and 9", rise_at, fall_at);
        end
    endtask

    task automatic test_simultaneous_and_reset();
        do_reset('0, 2);
        for (int k = 0; k < 7; k++) cyc(3'b001, 1'b0);
        for (int k = 0; k < 7; k++) begin
            cyc(3'b100, 1'b0);
            if (k == 5) begin
                checks++;
                if ({sw_db, sw_rise, sw_fall} !== {3'b100, 3'b100, 3'b001}) begin
                    errors++;
                    $display("FAIL simul_pulses got db=%b rise=%b fall=%b want db=100 rise=100 fall=001", sw_db, sw_rise, sw_fall);
                end
            end
        end
        for (int k = 0; k < 4; k++) cyc(3'b110, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if ({sw_db, sw_rise, sw_fall} !== '0) begin
            errors++;
            $display("FAIL simul_async_reset got db=%b rise=%b fall=%b want all 0", sw_db, sw_rise, sw_fall);
        end
        @(posedge clk);
        model_edge(sw_async, 1'b1);
        #1;
        for (int k = 0; k < 8; k++) begin
            cyc(3'b110, 1'b0);
            checks++;
            if ({sw_db, sw_rise, sw_fall} !== {m_db, m_rise, m_fall}) begin
                errors++;
                $display("FAIL simul_model k=%0d got db=%b rise=%b fall=%b want db=%b rise=%b fall=%b",
                         k, sw_db, sw_rise, sw_fall, m_db, m_rise, m_fall);
            end
            if (k == 4 || k == 5) begin
                checks++;
                if (sw_db !== ((k == 5) ? 3'b110 : 3'b000)) begin
                    errors++;
                    $display("FAIL simul_full_latency k=%0d got db=%b want %b", k, sw_db, (k == 5) ? 3'b110 : 3'b000);
                end
            end
        end
    endtask

    task automatic test_powerup();
        do_reset(3'b101, 3);
        for (int k = 0; k < 8; k++) begin
            cyc(3'b101, 1'b0);
`ifdef SWITCH_DEBOUNCE_INIT_SAMPLE_EN
            checks++;
            if (sw_rise !== 3'b000 || sw_db !== ((k >= 2) ? 3'b101 : 3'b000)) begin
                errors++;
                $display("FAIL powerup_init k=%0d got db=%b rise=%b want db=%b rise=000",
                         k, sw_db, sw_rise, (k >= 2) ? 3'b101 : 3'b000);
            end
`else
            checks++;
            if (sw_db !== ((k >= 5) ? 3'b101 : 3'b000) || sw_rise !== ((k == 5) ? 3'b101 : 3'b000)) begin
                errors++;
                $display("FAIL powerup_plain k=%0d got db=%b rise=%b want db=%b rise=%b",
                         k, sw_db, sw_rise, (k >= 5) ? 3'b101 : 3'b000, (k == 5) ? 3'b101 : 3'b000);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x = '0;
        int           hold = 0;
        logic         r;
        for (int n = 0; n < 900; n++) begin
            if (hold == 0) begin
                x    = W'($urandom);
                hold = $urandom_range(1, 7);
            end
            hold--;
            r = ($urandom_range(0, 99) == 0);
            cyc(x, r);
            checks++;
            if ({sw_db, sw_rise, sw_fall} !== {m_db, m_rise, m_fall}) begin
                errors++;
                $display("FAIL random_model n=%0d got db=%b rise=%b fall=%b want db=%b rise=%b fall=%b",
                         n, sw_db, sw_rise, sw_fall, m_db, m_rise, m_fall);
            end
            checks++;
            if ((sw_rise & sw_fall) !== '0) begin
                errors++;
                $display("FAIL random_both_pulses n=%0d got rise=%b fall=%b want disjoint", n, sw_rise, sw_fall);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        sw_async = '0;
        model_clear();
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_simultaneous_and_reset();
        test_powerup();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got no completion want finish before 1 ms");
        $fatal(1);
    end

endmodule
